// File: rtl/div_retire_unit.sv
// ============================================================================
// Module   : div_retire_unit
// Brief    : Retires divider results into a shared register-file write port
//            through an in-order FIFO. Optional retire trace enabled by the
//            macro DIV_RETIRE_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_retire_unit #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_valid,
   input  logic        div_get_rem,
   input  logic [4:0]  div_rd,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_remainder,
   input  logic [31:0] div_pc,
   input  logic [31:0] div_inst,
   input  logic        pipe_wb_we,
   input  logic [4:0]  query_addr,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        pending_hit,
   output logic        stall_req,
   output logic        overflow,
   output logic        trace_valid,
   output logic [31:0] trace_pc,
   output logic [31:0] trace_inst
);

   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(DEPTH / 2);

   logic [4:0]  fifo_rd_mem   [DEPTH];
   logic [31:0] fifo_data_mem [DEPTH];

   logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [c_cnt_w-1:0] count_q, count_d;
   logic               rf_we_q, rf_we_d;
   logic [4:0]         rf_waddr_q, rf_waddr_d;
   logic [31:0]        rf_wdata_q, rf_wdata_d;
   logic               stall_req_q, stall_req_d;
   logic               overflow_q, overflow_d;

   logic        w_in_data_sel;
   logic [31:0] w_in_data;
   logic        w_empty, w_full, w_pop, w_bypass, w_push_req, w_push, w_retire;
   logic [4:0]  w_ret_rd;
   logic [31:0] w_ret_data;

   assign w_in_data_sel = div_get_rem;
   assign w_in_data     = w_in_data_sel ? div_remainder : div_quotient;
   assign w_empty       = (count_q == '0);
   assign w_full        = (count_q == c_full);
   // The head always drains first; an empty FIFO lets the new result skip the queue.
   assign w_pop         = !pipe_wb_we && !w_empty;
   assign w_bypass      = !pipe_wb_we && w_empty && div_valid;
   assign w_push_req    = div_valid && !w_bypass;
   assign w_push        = w_push_req && (!w_full || w_pop);
   assign w_retire      = w_pop || w_bypass;
   assign w_ret_rd      = w_pop ? fifo_rd_mem[rd_ptr_q]   : div_rd;
   assign w_ret_data    = w_pop ? fifo_data_mem[rd_ptr_q] : w_in_data;

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_rd_mem[wr_ptr_q]   <= div_rd;
         fifo_data_mem[wr_ptr_q] <= w_in_data;
      end
   end

   always_comb begin
      rd_ptr_d    = w_pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
      wr_ptr_d    = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
      count_d     = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      stall_req_d = (count_d >= c_half);
      overflow_d  = overflow_q || (w_push_req && w_full && !w_pop);
      rf_we_d     = w_retire && (w_ret_rd != 5'd0);
      rf_waddr_d  = w_retire ? w_ret_rd   : rf_waddr_q;
      rf_wdata_d  = w_retire ? w_ret_data : rf_wdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         stall_req_q <= 1'b0;
         overflow_q  <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         stall_req_q <= stall_req_d;
         overflow_q  <= overflow_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // An entry is live when its distance from the head is below the count.
   always_comb begin
      logic              hit;
      logic [c_ptr_w-1:0] offs;
      hit  = 1'b0;
      offs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = c_ptr_w'(i) - rd_ptr_q;
         if (({1'b0, offs} < count_q) && (fifo_rd_mem[i] == query_addr)) begin
            hit = 1'b1;
         end
      end
      if (rf_we_q && (rf_waddr_q == query_addr)) begin
         hit = 1'b1;
      end
      pending_hit = hit && (query_addr != 5'd0);
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign stall_req = stall_req_q;
   assign overflow  = overflow_q;

`ifdef DIV_RETIRE_TRACE_EN
   logic [31:0] fifo_pc_mem   [DEPTH];
   logic [31:0] fifo_inst_mem [DEPTH];
   logic        trace_valid_q, trace_valid_d;
   logic [31:0] trace_pc_q, trace_pc_d, trace_inst_q, trace_inst_d;

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_pc_mem[wr_ptr_q]   <= div_pc;
         fifo_inst_mem[wr_ptr_q] <= div_inst;
      end
   end

   always_comb begin
      trace_valid_d = w_retire;
      trace_pc_d    = 32'd0;
      trace_inst_d  = 32'd0;
      if (w_retire) begin
         trace_pc_d   = w_pop ? fifo_pc_mem[rd_ptr_q]   : div_pc;
         trace_inst_d = w_pop ? fifo_inst_mem[rd_ptr_q] : div_inst;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trace_valid_q <= 1'b0;
         trace_pc_q    <= '0;
         trace_inst_q  <= '0;
      end else begin
         trace_valid_q <= trace_valid_d;
         trace_pc_q    <= trace_pc_d;
         trace_inst_q  <= trace_inst_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_pc    = trace_pc_q;
   assign trace_inst  = trace_inst_q;
`else
   logic unused_trace;
   assign unused_trace = ^{div_pc, div_inst};
   assign trace_valid  = 1'b0;
   assign trace_pc     = 32'd0;
   assign trace_inst   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/div_retire_unit.md
DIV_RETIRE_UNIT -- requirements
Module: div_retire_unit

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the retire FIFO entries (power of two, 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, the reset; asynchronous and active-high.
REQ-004 The module SHALL have port div_valid, input, 1 bit, which is divider tag stage 7 bit 6 (is_div_op).
REQ-005 The module SHALL have port div_get_rem, input, 1 bit, which is tag stage 7 bit 5 and selects remainder over quotient.
REQ-006 The module SHALL have port div_rd, input, 5 bits, which is tag stage 7 bits 4:0 and is the destination register.
REQ-007 The module SHALL have ports div_quotient and div_remainder, inputs, 32 bits each, the divider outputs aligned with tag stage 7.
REQ-008 The module SHALL have ports div_pc and div_inst, inputs, 32 bits each, the trace values of the completing divide.
REQ-009 The module SHALL have port pipe_wb_we, input, 1 bit; high means the main writeback owns the register-file write port this cycle.
REQ-010 The module SHALL have port query_addr, input, 5 bits, the register address checked for a pending divide write.
REQ-011 The module SHALL have ports rf_we, output, 1 bit; rf_waddr, output, 5 bits; and rf_wdata, output, 32 bits, forming the registered divide write port.
REQ-012 The module SHALL have port pending_hit, output, 1 bit, combinational; high when query_addr is nonzero and matches any valid FIFO entry or a valid rf_waddr.
REQ-013 The module SHALL have port stall_req, output, 1 bit, registered; it asks the issue logic to hold new divides.
REQ-014 The module SHALL have port overflow, output, 1 bit, a sticky error flag.
REQ-015 The module SHALL have ports trace_valid, output, 1 bit; trace_pc, output, 32 bits; and trace_inst, output, 32 bits, giving the retire trace.

Function
REQ-016 Incoming entry SHALL be {rd=div_rd, data=div_get_rem ? div_remainder : div_quotient, pc, inst}, taken when div_valid=1.
REQ-017 Port free (pipe_wb_we=0), FIFO non-empty: head SHALL pop into output register next edge; rf_we=1 for exactly that cycle.
REQ-018 Port free, FIFO empty, div_valid=1: incoming SHALL go directly to output register (1-cycle latency), not enqueued.
REQ-019 Port free, FIFO non-empty, div_valid=1: head pops, incoming SHALL push to tail; count unchanged; program order preserved.
REQ-020 Port busy (pipe_wb_we=1): rf_we SHALL be 0 next cycle; incoming, if any, SHALL push; no pop.
REQ-021 Entries with rd=0 SHALL retire in order with rf_we=0 but still occupy their slot and emit trace.
REQ-022 Push when count==DEPTH with no simultaneous pop: entry SHALL be dropped, overflow set until reset.
REQ-023 stall_req SHALL be 1 when count >= DEPTH/2, else 0 (registered from next-state count).
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH exactly.
REQ-025 Outputs SHALL be idle (rf_we=0, trace_valid=0) in every cycle nothing retires; rf_waddr/rf_wdata hold last value.

Reset
REQ-026 rst=1 SHALL asynchronously clear FIFO count and pointers, rf_we, rf_waddr, rf_wdata, stall_req, overflow, trace outputs to 0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight retirements; first post-reset retire needs new div_valid.

Configuration
REQ-028 Macro DIV_RETIRE_TRACE_EN defined: trace_valid pulses with each retirement (incl. rd=0), trace_pc/trace_inst from that entry.
REQ-029 Macro DIV_RETIRE_TRACE_EN undefined: pc/inst SHALL not be stored; trace_valid, trace_pc, trace_inst tied 0.

Verification
REQ-030 Port free, div_valid=1, rd=5, get_rem=0, quotient=0x7 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x7.
REQ-031 pipe_wb_we=1 for 3 cycles, divides rd=1,2,3 arrive -> rf_we=0 throughout; then writes rd 1,2,3 on 3 consecutive cycles.
REQ-032 Queue rd=9 while port busy, query_addr=9 -> pending_hit=1 until retire cycle ends; query_addr=0 -> pending_hit=0.
REQ-033 DEPTH=8, port held busy, 9 divides -> stall_req=1 after 4th push, overflow=1 after 9th, count=8.
REQ-034 Divide get_rem=1, remainder=0xFFFFFFFF, rd=0 -> rf_we stays 0; trace_valid=1 with trace_pc=div_pc (TRACE_EN on).
REQ-035 rst asserted with 3 queued entries -> rf_we=0, count=0 immediately; no writes after release.
